// File: rtl/rtc_timekeeper.sv
// Real-time-clock core: prescaled 1 Hz tick, BCD HH:MM:SS (24 h internal),
// debounced set buttons with auto-repeat, and six active-low 7-segment digits.
module rtc_timekeeper #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_CYCLES   = 12_500_000
) (
  input  logic            clock50MHz,
  input  logic            resetn,
  input  logic [2:0]      push_button,
  input  logic            man_switch,
  input  logic            mode_12h,
  output logic            tick_1hz,
  output logic [7:0]      hh_bcd,
  output logic [7:0]      mm_bcd,
  output logic [7:0]      ss_bcd,
  output logic            pm,
  output logic            colon_blink,
  output logic [5:0][6:0] seven_seg
);

  localparam int PS_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_FREQ_HZ - 1);
  localparam logic [PS_W-1:0] PS_PRE  = PS_W'(CLK_FREQ_HZ - 2);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(CLK_FREQ_HZ / 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [1:0]            sw_sync;
  logic                  set_mode;
  logic                  mode12_q;
  logic [PS_W-1:0]       ps_cnt;

  logic [2:0]            btn_s1;
  logic [2:0]            btn_s2;
  logic [2:0]            db_lvl;
  logic [2:0]            db_lvl_q;
  logic [2:0][DB_W-1:0]  db_cnt;
  logic [2:0][RP_W-1:0]  rp_cnt;
  logic [2:0]            btn_evt;

  logic [7:0]            ss_nxt;
  logic [7:0]            mm_nxt;
  logic [7:0]            hh_nxt;

  logic [4:0]            h_bin;
  logic [4:0]            h12;
  logic [3:0]            dig_h1;
  logic [3:0]            dig_h0;
  logic                  blank_h1;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign set_mode = sw_sync[1];

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      sw_sync  <= 2'b00;
      mode12_q <= 1'b0;
    end else begin
      sw_sync  <= {sw_sync[0], man_switch};
      mode12_q <= mode_12h;
    end
  end

  // Tick is raised one cycle ahead of the terminal count so it is high exactly
  // while ps_cnt == CLK_FREQ_HZ-1; it is suppressed once the switch has synced high.
  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      ps_cnt   <= '0;
      tick_1hz <= 1'b0;
    end else begin
      if (set_mode || ps_cnt == PS_LAST)
        ps_cnt <= '0;
      else
        ps_cnt <= ps_cnt + 1'b1;
      tick_1hz <= !sw_sync[0] && !set_mode && (ps_cnt == PS_PRE);
    end
  end

  assign colon_blink = set_mode | (ps_cnt < PS_HALF);

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      btn_s1   <= 3'b111;
      btn_s2   <= 3'b111;
      db_lvl   <= 3'b111;
      db_lvl_q <= 3'b111;
      db_cnt   <= '0;
      rp_cnt   <= '0;
      btn_evt  <= 3'b000;
    end else begin
      btn_s1   <= push_button;
      btn_s2   <= btn_s1;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= btn_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end

        // Repeat timer is a down-counter reloaded on the press and on every repeat.
        btn_evt[i] <= 1'b0;
        if (db_lvl[i]) begin
          rp_cnt[i] <= '0;
        end else if (db_lvl_q[i] || rp_cnt[i] == '0) begin
          rp_cnt[i]  <= RP_LAST;
          btn_evt[i] <= 1'b1;
        end else begin
          rp_cnt[i] <= rp_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    ss_nxt = ss_bcd;
    mm_nxt = mm_bcd;
    hh_nxt = hh_bcd;
    if (tick_1hz) begin
      ss_nxt = bcd_inc(ss_bcd, 8'h59);
      if (ss_bcd == 8'h59) begin
        mm_nxt = bcd_inc(mm_bcd, 8'h59);
        if (mm_bcd == 8'h59)
          hh_nxt = bcd_inc(hh_bcd, 8'h23);
      end
    end else if (set_mode) begin
      if (btn_evt[0]) ss_nxt = 8'h00;
      if (btn_evt[1]) mm_nxt = bcd_inc(mm_bcd, 8'h59);
      if (btn_evt[2]) hh_nxt = bcd_inc(hh_bcd, 8'h23);
    end
  end

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      ss_bcd <= 8'h00;
      mm_bcd <= 8'h00;
      hh_bcd <= 8'h00;
    end else begin
      ss_bcd <= ss_nxt;
      mm_bcd <= mm_nxt;
      hh_bcd <= hh_nxt;
    end
  end

  assign pm = (hh_bcd >= 8'h12);

  always_comb begin
    h_bin = 5'(hh_bcd[7:4]) * 5'd10 + 5'(hh_bcd[3:0]);
    h12   = h_bin;
    if (h_bin == 5'd0)
      h12 = 5'd12;
    else if (h_bin > 5'd12)
      h12 = h_bin - 5'd12;
    dig_h1   = hh_bcd[7:4];
    dig_h0   = hh_bcd[3:0];
    blank_h1 = 1'b0;
    if (mode12_q) begin
      blank_h1 = (h12 < 5'd10);
      dig_h1   = blank_h1 ? 4'd0 : 4'd1;
      dig_h0   = blank_h1 ? h12[3:0] : 4'(h12 - 5'd10);
    end
  end

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      seven_seg <= '1;
    end else begin
      seven_seg[5] <= blank_h1 ? 7'h7F : seg7(dig_h1);
      seven_seg[4] <= seg7(dig_h0);
      seven_seg[3] <= seg7(mm_bcd[7:4]);
      seven_seg[2] <= seg7(mm_bcd[3:0]);
      seven_seg[1] <= seg7(ss_bcd[7:4]);
      seven_seg[0] <= seg7(ss_bcd[3:0]);
    end
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench for rtc_timekeeper: an integer-time model queues every expected
// time change; a monitor pops and compares whenever the DUT time moves.
module tb_rtc_timekeeper;
  localparam int CLK = 10;
  localparam int DB  = 4;
  localparam int RP  = 20;

  logic            clock50MHz = 1'b0;
  logic            resetn;
  logic [2:0]      push_button;
  logic            man_switch;
  logic            mode_12h;
  logic            tick_1hz;
  logic [7:0]      hh_bcd, mm_bcd, ss_bcd;
  logic            pm;
  logic            colon_blink;
  logic [5:0][6:0] seven_seg;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  int          m_h = 0, m_m = 0, m_s = 0;
  int          tick_cnt = 0;
  int          last_tick = -1;
  int          cyc = 0;
  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  rtc_timekeeper #(.CLK_FREQ_HZ(CLK), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clock50MHz (clock50MHz),
    .resetn     (resetn),
    .push_button(push_button),
    .man_switch (man_switch),
    .mode_12h   (mode_12h),
    .tick_1hz   (tick_1hz),
    .hh_bcd     (hh_bcd),
    .mm_bcd     (mm_bcd),
    .ss_bcd     (ss_bcd),
    .pm         (pm),
    .colon_blink(colon_blink),
    .seven_seg  (seven_seg)
  );

  always #5 clock50MHz = ~clock50MHz;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [23:0] model_time();
    return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
  endfunction

  task automatic model_tick();
    m_s++;
    if (m_s == 60) begin
      m_s = 0;
      m_m++;
      if (m_m == 60) begin
        m_m = 0;
        m_h = (m_h + 1) % 24;
      end
    end
    exp_q.push_back(model_time());
  endtask

  task automatic model_event(input logic [2:0] mask);
    logic [23:0] old;
    old = model_time();
    if (mask[0]) m_s = 0;
    if (mask[1]) m_m = (m_m + 1) % 60;
    if (mask[2]) m_h = (m_h + 1) % 24;
    if (model_time() != old) exp_q.push_back(model_time());
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock50MHz);
    #1;
  endtask

  task automatic check_display();
    int hd, tens, ones;
    logic [6:0] e5;
    hd   = mode_12h ? ((m_h % 12 == 0) ? 12 : m_h % 12) : m_h;
    tens = hd / 10;
    ones = hd % 10;
    e5   = (mode_12h && tens == 0) ? 7'h7F : seg_tab[tens];
    chk("seg5", seven_seg[5], e5);
    chk("seg4", seven_seg[4], seg_tab[ones]);
    chk("seg3", seven_seg[3], seg_tab[m_m / 10]);
    chk("seg2", seven_seg[2], seg_tab[m_m % 10]);
    chk("seg1", seven_seg[1], seg_tab[m_s / 10]);
    chk("seg0", seven_seg[0], seg_tab[m_s % 10]);
    chk("pm_static", pm, m_h >= 12);
  endtask

  // A press held for `hold` cycles yields a debounced low of the same length:
  // one event at acceptance plus one per full repeat period that fits inside it.
  task automatic press(input logic [2:0] mask, input int hold);
    int n;
    n = (hold >= DB) ? 1 + (hold - 1) / RP : 0;
    for (int k = 0; k < n; k++) model_event(mask);
    push_button = ~mask;
    step(hold);
    push_button = 3'b111;
    step(DB + 12);
    chk("sb_drain_press", exp_q.size(), 0);
    check_display();
  endtask

  task automatic set_time(input int h, input int m);
    int nh, nm;
    nh = (h - m_h + 24) % 24;
    nm = (m - m_m + 60) % 60;
    if (nh > 0) press(3'b100, (nh - 1) * RP + 5);
    if (nm > 0) press(3'b010, (nm - 1) * RP + 5);
  endtask

  task automatic run_seg(input int k);
    for (int i = 0; i < k; i++) model_tick();
    man_switch = 1'b0;
    step(CLK * k + 5);
    man_switch = 1'b1;
    step(4);
    last_tick = -1;
    chk("sb_drain_run", exp_q.size(), 0);
    check_display();
  endtask

  initial begin : monitor
    logic [23:0] prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clock50MHz);
      cyc++;
      cur = {hh_bcd, mm_bcd, ss_bcd};
      if (cur != prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL time_unexpected: got %h expected no update (t=%0t)", cur, $time);
        end else begin
          e = exp_q.pop_front();
          chk("time", cur, e);
          chk("pm", pm, (e[23:20] * 10 + e[19:16]) >= 12);
        end
      end
      prev = cur;
      if (tick_1hz) begin
        tick_cnt++;
        chk("colon_at_tick", colon_blink, 0);
        if (last_tick >= 0) chk("tick_interval", cyc - last_tick, CLK);
        last_tick = cyc;
      end
    end
  end

  initial begin : stim
    int r, hold;
    logic [2:0] mask;
    resetn      = 1'b0;
    push_button = 3'b111;
    man_switch  = 1'b0;
    mode_12h    = 1'b0;
    step(3);
    chk("rst_time", {hh_bcd, mm_bcd, ss_bcd}, 0);
    chk("rst_tick", tick_1hz, 0);
    chk("rst_colon", colon_blink, 1);
    chk("rst_pm", pm, 0);
    for (int i = 0; i < 6; i++) chk("rst_seg", seven_seg[i], 7'h7F);

    // Tick rate: ten seconds in a little over 100 cycles.
    for (int i = 0; i < 10; i++) model_tick();
    tick_cnt = 0;
    resetn = 1'b1;
    step(105);
    chk("tick_count", tick_cnt, 10);
    chk("ss_after_100", ss_bcd, 8'h10);
    chk("seg1_after_100", seven_seg[1], 7'h79);
    chk("seg0_after_100", seven_seg[0], 7'h40);

    // Set mode freezes the prescaler.
    man_switch = 1'b1;
    step(4);
    last_tick = -1;
    tick_cnt = 0;
    step(30);
    chk("freeze_ticks", tick_cnt, 0);
    chk("freeze_colon", colon_blink, 1);

    // Debounce and repeat.
    press(3'b010, 3);
    press(3'b010, 5);
    press(3'b010, 74);

    // Minute wrap without hour carry.
    set_time(5, 59);
    press(3'b010, 5);
    chk("wrap_mm", mm_bcd, 8'h00);
    chk("wrap_hh", hh_bcd, 8'h05);

    // Midnight rollover.
    set_time(23, 59);
    press(3'b001, 5);
    run_seg(60);
    chk("midnight", {hh_bcd, mm_bcd, ss_bcd}, 0);
    chk("midnight_pm", pm, 0);

    // 12-hour display.
    mode_12h = 1'b1;
    set_time(13, 0);
    step(3);
    chk("h13_seg5", seven_seg[5], 7'h7F);
    chk("h13_seg4", seven_seg[4], 7'h79);
    chk("h13_pm", pm, 1);
    set_time(0, 0);
    step(3);
    chk("h00_seg5", seven_seg[5], 7'h79);
    chk("h00_seg4", seven_seg[4], 7'h24);
    chk("h00_pm", pm, 0);

    // Randomized mix of presses, run segments and display mode changes.
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: begin
          mask = 3'($urandom_range(1, 7));
          if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, 3);
          else hold = $urandom_range(5, 70);
          if (hold >= 5 && (hold % RP <= 1 || hold % RP == RP - 1)) hold += 3;
          press(mask, hold);
        end
        1: run_seg($urandom_range(1, 4));
        2: begin
          mode_12h = ~mode_12h;
          step(3);
          check_display();
        end
        default: set_time($urandom_range(0, 23), $urandom_range(0, 59));
      endcase
    end

    // Reset while a button is held at 12:34:56.
    mode_12h = 1'b0;
    set_time(12, 34);
    press(3'b001, 5);
    run_seg(56);
    chk("pre_reset_time", {hh_bcd, mm_bcd, ss_bcd}, 24'h123456);
    m_h = 0; m_m = 0; m_s = 0;
    exp_q.push_back(24'h000000);
    push_button = 3'b101;
    step(2);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_time", {hh_bcd, mm_bcd, ss_bcd}, 0);
    chk("mid_rst_tick", tick_1hz, 0);
    chk("mid_rst_colon", colon_blink, 1);
    chk("mid_rst_pm", pm, 0);
    for (int i = 0; i < 6; i++) chk("mid_rst_seg", seven_seg[i], 7'h7F);
    push_button = 3'b111;
    step(3);
    resetn = 1'b1;
    step(50);
    chk("post_rst_quiet", {hh_bcd, mm_bcd, ss_bcd}, 0);
    press(3'b010, 5);
    chk("post_rst_press", {hh_bcd, mm_bcd, ss_bcd}, 24'h000100);

    step(5);
    chk("sb_final", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
